sram_sdp_clr: RTL and testbench

Parametrised simple-dual-port SRAM with one write port, one read port, registered read data with a valid flag, and a hardware clear sequencer that zeroes the array one word per cycle. Used as the path-metric and survivor/traceback store of the Viterbi decoder, where the ACS stage writes while traceback reads in the same cycle. Replaces the fixed 24x2048 single-port store; read data is always driven, never high-impedance.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_clr_ctrl.sv | 71 +++++++
 rtl/sram_sdp_clr.sv | 111 +++++++++++
 tb/tb_sram_sdp_clr.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants, clear-FSM state type and address-range helper for the
// simple-dual-port SRAM with hardware clear.
package sram_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int DEPTH_DEF  = 2048;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic addr_ok(input int addr, input int depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/sram_clr_ctrl.sv
// Clear sequencer: walks the array writing zero one word per cycle and muxes
// that zero-write onto the array write port in place of the user write.
module sram_clr_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              busy_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              w_clearing;
  logic              w_user_we;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_i) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_clearing = (r_state == CLEAR);
  assign w_user_we  = wr_en_i && addr_ok(32'(wr_addr_i), DEPTH);

  // Writes are suppressed during reset; the restarted sweep rewrites everything.
  assign mem_we_o   = !rst_i && (w_clearing || w_user_we);
  assign mem_addr_o = w_clearing ? r_cnt : wr_addr_i;
  assign mem_data_o = w_clearing ? '0 : wr_data_i;
  assign busy_o     = r_busy;

endmodule

// File: rtl/sram_sdp_clr.sv
// Simple-dual-port SRAM with registered read, valid flag and hardware clear.
// Define SRAM_SDP_WR_FWD_EN for write-first same-address behaviour.
module sram_sdp_clr
  import sram_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = addr_w(DEPTH),
  parameter int OUT_REG = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  output logic              busy_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  logic              w_busy;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic              w_rd_fire;
  logic              w_fwd;
  logic [DATA_W-1:0] w_rd_word;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  sram_clr_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_ctrl (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .busy_o     (w_busy),
    .mem_we_o   (w_mem_we),
    .mem_addr_o (w_mem_addr),
    .mem_data_o (w_mem_data)
  );

  // NOTE: the array has no reset so it maps onto block RAM; the clear
  // sequencer is what zeroes its contents.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

`ifdef SRAM_SDP_WR_FWD_EN
  assign w_fwd = wr_en_i && (wr_addr_i == rd_addr_i);
`else
  assign w_fwd = 1'b0;
`endif

  assign w_rd_fire = rd_en_i && !w_busy;
  assign w_rd_word = !addr_ok(32'(rd_addr_i), DEPTH) ? '0 :
                     w_fwd                           ? wr_data_i :
                                                       r_mem[rd_addr_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] r_out_data;
      logic              r_out_valid;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= r_rd_valid;
          if (r_rd_valid) begin
            r_out_data <= r_rd_data;
          end
        end
      end

      assign rd_data_o  = r_out_data;
      assign rd_valid_o = r_out_valid;
    end else begin : g_no_out_reg
      assign rd_data_o  = r_rd_data;
      assign rd_valid_o = r_rd_valid;
    end
  endgenerate

  assign busy_o = w_busy;

endmodule

// File: tb/tb_sram_sdp_clr.sv
// Directed bench: instance A (2048 words, latency 1) and instance B
// (1000 words, output register, latency 2).
module tb_sram_sdp_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_clr, a_busy, a_wr_en, a_rd_en, a_rd_valid;
  logic [10:0] a_wr_addr, a_rd_addr;
  logic [23:0] a_wr_data, a_rd_data;

  logic        b_rst, b_clr, b_busy, b_wr_en, b_rd_en, b_rd_valid;
  logic [9:0]  b_wr_addr, b_rd_addr;
  logic [23:0] b_wr_data, b_rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n, nb;

  sram_sdp_clr #(.DATA_W(24), .DEPTH(2048), .OUT_REG(0)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .clr_i(a_clr), .busy_o(a_busy),
    .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
    .rd_en_i(a_rd_en), .rd_addr_i(a_rd_addr),
    .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid)
  );

  sram_sdp_clr #(.DATA_W(24), .DEPTH(1000), .OUT_REG(1)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .clr_i(b_clr), .busy_o(b_busy),
    .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
    .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr),
    .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef SRAM_SDP_WR_FWD_EN
  localparam logic [23:0] EXP_SAME = 24'h222222;
`else
  localparam logic [23:0] EXP_SAME = 24'h111111;
`endif

  initial begin
    a_rst = 1'b1; a_clr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0;
    b_rst = 1'b1; b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;

    step();
    step();
    check("a_rst_busy",  a_busy, 1);
    check("a_rst_valid", a_rd_valid, 0);
    check("a_rst_data",  a_rd_data, 0);
    check("b_rst_busy",  b_busy, 1);
    check("b_rst_valid", b_rd_valid, 0);
    check("b_rst_data",  b_rd_data, 0);

    // Sweep after reset release: count cycles with busy high.
    a_rst = 1'b0;
    b_rst = 1'b0;
    n  = 0;
    nb = 0;
    while (a_busy === 1'b1 && n < 5000) begin
      if (b_busy === 1'b1) nb++;
      step();
      n++;
    end
    check("a_busy_cycles", n, 2048);
    check("b_busy_cycles", nb, 1000);

    // First IDLE cycle: back-to-back reads of cleared words.
    a_rd_en = 1'b1;
    a_rd_addr = 11'd2047; step();
    check("rd2047_valid", a_rd_valid, 1);
    check("rd2047_data",  a_rd_data, 0);
    a_rd_addr = 11'd0; step();
    check("rd0_valid", a_rd_valid, 1);
    check("rd0_data",  a_rd_data, 0);
    a_rd_addr = 11'd1000; step();
    check("rd1000_valid", a_rd_valid, 1);
    check("rd1000_data",  a_rd_data, 0);
    a_rd_en = 1'b0; step();
    check("rd_valid_pulse", a_rd_valid, 0);

    // Write then read next cycle, then hold with no read.
    a_wr_en = 1'b1; a_wr_addr = 11'd5; a_wr_data = 24'hABCDEF; step();
    a_wr_en = 1'b0; a_rd_en = 1'b1; a_rd_addr = 11'd5; step();
    a_rd_en = 1'b0;
    check("rd5_valid", a_rd_valid, 1);
    check("rd5_data",  a_rd_data, 24'hABCDEF);
    step();
    check("hold_valid", a_rd_valid, 0);
    check("hold_data",  a_rd_data, 24'hABCDEF);

    // Same-cycle same-address write and read.
    a_wr_en = 1'b1; a_wr_addr = 11'd7; a_wr_data = 24'h111111; step();
    a_wr_data = 24'h222222; a_rd_en = 1'b1; a_rd_addr = 11'd7; step();
    a_wr_en = 1'b0;
    check("same_addr_data", a_rd_data, EXP_SAME);
    step();
    a_rd_en = 1'b0;
    check("after_same_data", a_rd_data, 24'h222222);

    // Fill 0..15, then full-rate reads in issue order.
    a_wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_wr_addr = 11'(i);
      a_wr_data = 24'h000100 + 24'(i);
      step();
    end
    a_wr_en = 1'b0;
    a_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_rd_addr = 11'(i);
      step();
      check("b2b_data", a_rd_data, 24'h000100 + 24'(i));
    end
    a_rd_en = 1'b0;

    // Clear pulse, reset at sweep cycle 10, busy-time accesses ignored.
    a_clr = 1'b1; step();
    a_clr = 1'b0;
    check("clr_busy", a_busy, 1);
    repeat (9) step();
    a_rst = 1'b1; step();
    a_rst = 1'b0;
    a_clr = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 11'd9; a_wr_data = 24'h555555;
    a_rd_en = 1'b1; a_rd_addr = 11'd9;
    step();
    n = 1;
    a_clr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    check("busy_rd_valid", a_rd_valid, 0);
    check("busy_rd_data",  a_rd_data, 0);
    while (a_busy === 1'b1 && n < 5000) begin
      step();
      n++;
    end
    check("restart_busy_cycles", n, 2048);
    a_rd_en = 1'b1;
    a_rd_addr = 11'd3;  step();
    check("clr3_data", a_rd_data, 0);
    a_rd_addr = 11'd9;  step();
    check("clr9_data", a_rd_data, 0);
    a_rd_addr = 11'd15; step();
    check("clr15_data", a_rd_data, 0);
    check("clr15_valid", a_rd_valid, 1);
    a_rd_en = 1'b0;

    // Instance B: latency 2 and out-of-range address.
    b_wr_en = 1'b1;
    b_wr_addr = 10'd999;  b_wr_data = 24'h654321; step();
    b_wr_addr = 10'd1010; b_wr_data = 24'h123456; step();
    b_wr_addr = 10'd5;    b_wr_data = 24'hABCDEF; step();
    b_wr_en = 1'b0;
    b_rd_en = 1'b1; b_rd_addr = 10'd5; step();
    check("b_lat2_not_yet", b_rd_valid, 0);
    b_rd_addr = 10'd1010; step();
    check("b_rd5_valid", b_rd_valid, 1);
    check("b_rd5_data",  b_rd_data, 24'hABCDEF);
    b_rd_addr = 10'd999; step();
    b_rd_en = 1'b0;
    check("b_oor_valid", b_rd_valid, 1);
    check("b_oor_data",  b_rd_data, 0);
    step();
    check("b_rd999_valid", b_rd_valid, 1);
    check("b_rd999_data",  b_rd_data, 24'h654321);
    step();
    check("b_idle_valid", b_rd_valid, 0);
    check("b_idle_data",  b_rd_data, 24'h654321);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
